// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven prescaled up-counter with periodic and
// one-shot modes. Commands load the limit and prescale registers, start
// a run or stop it. A registered tick pulses one cycle after the count
// reaches its limit on an increment event.
module counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD_LIMIT    = 2'd0;
  localparam logic [1:0] OP_LOAD_PRESCALE = 2'd1;
  localparam logic [1:0] OP_START         = 2'd2;
  localparam logic [1:0] OP_STOP          = 2'd3;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic             tick_q,     tick_d;
  logic [WIDTH-1:0] psc_q,      psc_d;
  logic [WIDTH-1:0] limit_q,    limit_d;
  logic [WIDTH-1:0] prescale_q, prescale_d;
  logic             mode_q,     mode_d;   // 1 = periodic, 0 = one-shot
  logic             accept;

  // While running only STOP may be taken, so limit and prescale stay
  // stable for the whole run and count can never exceed limit.
  assign cmd_ready = (state_q != ST_RUN) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid && cmd_ready;

  assign count = count_q;
  assign tick  = tick_q;
  assign busy  = (state_q == ST_RUN);
  assign state = state_q;

  // Next-state logic: command handling outside RUN, prescaled counting in RUN.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tick_d     = 1'b0;
    psc_d      = psc_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          // Only STOP reaches here; it wins over any increment or tick.
          state_d = ST_IDLE;
        end else if (psc_q == prescale_q) begin
          psc_d = '0;
          if (count_q != limit_q) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            tick_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              state_d = ST_DONE;
            end
          end
        end else begin
          psc_d = psc_q + WIDTH'(1);
        end
      end
      default: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD_LIMIT:    limit_d    = cmd_data;
            OP_LOAD_PRESCALE: prescale_d = cmd_data;
            OP_START: begin
              count_d = '0;
              psc_d   = '0;
              mode_d  = cmd_data[0];
              state_d = ST_RUN;
            end
            default:          state_d    = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      tick_q     <= 1'b0;
      psc_q      <= '0;
      limit_q    <= '1;
      prescale_q <= '0;
      mode_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      psc_q      <= psc_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
    end
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of count, limit and prescale registers.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_op  input  2  opcode: 0 LOAD_LIMIT, 1 LOAD_PRESCALE, 2 START, 3 STOP.
REQ-006 Port: cmd_data  input  WIDTH  operand; for START, bit0 = periodic mode (1) or one-shot (0).
REQ-007 Port: cmd_ready  output  1  command accepted this edge if cmd_valid && cmd_ready.
REQ-008 Port: count  output  WIDTH  current counter value, registered.
REQ-009 Port: tick  output  1  one-cycle registered pulse on terminal count.
REQ-010 Port: busy  output  1  high while state = RUN.
REQ-011 Port: state  output  2  FSM encoding: IDLE=0, RUN=1, DONE=2; 3 unused.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; encoding 3 is never entered.
REQ-013 cmd_ready SHALL be combinational: 1 when state != RUN, or when cmd_op = STOP.
REQ-014 Accepted LOAD_LIMIT SHALL write cmd_data to limit; accepted LOAD_PRESCALE SHALL write cmd_data to prescale; state, count and tick unchanged.
REQ-015 Accepted START in IDLE or DONE SHALL clear count to 0, clear prescale counter to 0, latch mode from cmd_data[0] and enter RUN next cycle.
REQ-016 Accepted STOP in RUN SHALL enter IDLE, hold count and suppress any increment or tick in that cycle; STOP in IDLE or DONE SHALL enter IDLE with count held.
REQ-017 In RUN the prescale counter SHALL increment each clk; when it equals prescale, an increment event occurs and it returns to 0, giving one event per prescale+1 cycles.
REQ-018 On an increment event with count != limit, count SHALL become count+1.
REQ-019 On an increment event with count = limit: tick SHALL be 1 in the following cycle; periodic mode sets count to 0 and stays in RUN; one-shot holds count at limit and enters DONE.
REQ-020 limit = 0 SHALL produce a tick on every increment event with count held at 0 (periodic) or DONE after the first event (one-shot).
REQ-021 count SHALL never exceed limit in RUN; count > limit SHALL never occur because limit is writable only outside RUN; count wraps only via REQ-019, never by modulo-2^WIDTH overflow.
REQ-022 tick SHALL be 0 in every cycle not immediately following a terminal event.
REQ-023 busy SHALL equal (state == RUN) combinationally.
REQ-024 The first increment event after START SHALL occur prescale+1 cycles after the START edge.

Reset
REQ-025 rst_n low SHALL immediately force state = IDLE, count = 0, tick = 0, prescale counter = 0, limit = all-ones, prescale = 0, mode = periodic.
REQ-026 Reset asserted mid-RUN SHALL abort without a tick; after release the block SHALL remain in IDLE until a START.
REQ-027 Release of rst_n SHALL be synchronised externally; the block samples no command on the release edge.

Verification
REQ-028 Reset, START(data=1), prescale 0, limit 255 -> count 0,1,...,255 on successive cycles, tick one cycle after count=255, count then 0; no other ticks.
REQ-029 LOAD_LIMIT 3, LOAD_PRESCALE 2, START(data=0) -> count increments every 3 cycles 0->1->2->3, tick once, state DONE, count held at 3, busy 0.
REQ-030 In RUN, LOAD_LIMIT with cmd_valid high -> cmd_ready 0, limit unchanged; STOP issued in the same cycle as a terminal event -> state IDLE, count unchanged, no tick.
REQ-031 LOAD_LIMIT 0, START(data=1), prescale 0 -> tick high every cycle from the second cycle after START, count constant 0.
REQ-032 rst_n asserted mid-RUN at count 5 -> count 0, state IDLE, tick 0 asynchronously; START after release restarts counting from 0 with limit all-ones.
REQ-033 START(data=0) from DONE -> count cleared to 0, RUN re-entered, second one-shot completes with a single tick.
